// File: rtl/sha256_core_mb.sv
// sha256_core_mb: multi-block SHA-256 compression core, 1/2/4 rounds per cycle.
// Optional SHA-224 output mode enabled by defining SHA256_CORE_SHA224_EN.
module sha256_core_mb #(
  parameter int    rounds_per_cycle_p = 1,
  parameter string core_id_p          = "inv"
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  input  logic         v_i,
  output logic         ready_o,
  input  logic [511:0] msg_i,
  input  logic         first_i,
  input  logic         last_i,
`ifdef SHA256_CORE_SHA224_EN
  input  logic         mode_i,
`endif
  output logic         v_o,
  input  logic         yumi_i,
  output logic [255:0] digest_o
);

  localparam int R = rounds_per_cycle_p;

  localparam logic [7:0][31:0] IV256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {eIdle, eBusy, eFinal, eDone} state_e;

  state_e            r_state;
  logic [7:0][31:0]  r_h;
  logic [7:0][31:0]  r_v;
  logic [15:0][31:0] r_win;
  logic [5:0]        r_cnt;
  logic              r_last;
  logic [255:0]      r_dig;
`ifdef SHA256_CORE_SHA224_EN
  logic              r_mode;
`endif

  logic [7:0][31:0]  w_iv;
  logic [15:0][31:0] w_msg_win;
  logic [7:0][31:0]  w_v_nxt;
  logic [15:0][31:0] w_win_nxt;
  logic [7:0][31:0]  w_h_sum;
  logic [255:0]      w_dig_nxt;
  logic [6:0]        w_cnt_sum;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] f_bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] f_bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  // Window slot 0 always holds Wt; slot 15 receives W(t+16).
  function automatic logic [31:0] f_next_w(input logic [15:0][31:0] w);
    return f_sig1(w[14]) + w[9] + f_sig0(w[1]) + w[0];
  endfunction

  // Word 0 is a, word 7 is h.
  function automatic logic [7:0][31:0] f_round(
    input logic [7:0][31:0] v,
    input logic [31:0]      wt,
    input logic [31:0]      kt
  );
    logic [31:0]      t1;
    logic [31:0]      t2;
    logic [7:0][31:0] r;
    t1 = v[7] + f_bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt + wt;
    t2 = f_bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    r[0] = t1 + t2;
    r[1] = v[0];
    r[2] = v[1];
    r[3] = v[2];
    r[4] = v[3] + t1;
    r[5] = v[4];
    r[6] = v[5];
    r[7] = v[6];
    return r;
  endfunction

  // Unrolled R rounds plus schedule advance, and block/IV/finalisation helpers.
  always_comb begin : round_logic
    logic [7:0][31:0]  v;
    logic [15:0][31:0] w;
    v = r_v;
    w = r_win;
    for (int k = 0; k < R; k++) begin
      v = f_round(v, w[0], K[r_cnt + 6'(k)]);
      w = {f_next_w(w), w[15:1]};
    end
    w_v_nxt   = v;
    w_win_nxt = w;
    w_cnt_sum = {1'b0, r_cnt} + 7'(R);
    for (int i = 0; i < 16; i++) begin
      w_msg_win[i] = msg_i[511 - 32*i -: 32];
    end
    for (int i = 0; i < 8; i++) begin
      w_h_sum[i] = r_h[i] + r_v[i];
    end
`ifdef SHA256_CORE_SHA224_EN
    w_iv = mode_i ? {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                     32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8}
                  : IV256;
    w_dig_nxt = r_mode ? {32'h0, w_h_sum[223:0]} : w_h_sum;
`else
    w_iv      = IV256;
    w_dig_nxt = w_h_sum;
`endif
  end

  // Control FSM with datapath registers; en_i low freezes everything.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= eIdle;
      r_cnt   <= '0;
      r_h     <= IV256;
      r_v     <= '0;
      r_win   <= '0;
      r_last  <= 1'b0;
      r_dig   <= '0;
`ifdef SHA256_CORE_SHA224_EN
      r_mode  <= 1'b0;
`endif
    end else if (en_i) begin
      unique case (r_state)
        eIdle: begin
          if (v_i) begin
            r_win  <= w_msg_win;
            r_last <= last_i;
            r_cnt  <= '0;
            if (first_i) begin
              r_h <= w_iv;
              r_v <= w_iv;
`ifdef SHA256_CORE_SHA224_EN
              r_mode <= mode_i;
`endif
            end else begin
              r_v <= r_h;
            end
            r_state <= eBusy;
          end
        end
        eBusy: begin
          r_v   <= w_v_nxt;
          r_win <= w_win_nxt;
          r_cnt <= w_cnt_sum[5:0];
          if (w_cnt_sum[6]) r_state <= eFinal;
        end
        eFinal: begin
          r_h <= w_h_sum;
          if (r_last) begin
            r_dig   <= w_dig_nxt;
            r_state <= eDone;
          end else begin
            r_state <= eIdle;
          end
        end
        eDone: begin
          if (yumi_i) r_state <= eIdle;
        end
        default: r_state <= eIdle;
      endcase
    end
  end

  assign ready_o  = (r_state == eIdle);
  assign v_o      = (r_state == eDone);
  assign digest_o = r_dig;

endmodule

// File: tb/tb_sha256_core_mb.sv
// tb_sha256_core_mb: directed known-answer bench for sha256_core_mb
// with R=1, R=2 and R=4 instances sharing message/flag inputs.
module tb_sha256_core_mb;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [2:0]   en_i;
  logic [2:0]   v_i;
  logic [2:0]   yumi_i;
  logic [2:0]   ready_o;
  logic [2:0]   v_o;
  logic [511:0] msg_i;
  logic         first_i;
  logic         last_i;
  logic [255:0] dig [3];
`ifdef SHA256_CORE_SHA224_EN
  logic         mode_i;
`endif

  int nchk = 0;
  int nerr = 0;

  localparam logic [511:0] MSG_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MSG_B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
  localparam logic [255:0] DIG_2B = {
    32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
    32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};
`ifdef SHA256_CORE_SHA224_EN
  localparam logic [255:0] DIG_224 = {
    32'h00000000, 32'he36c9da7, 32'hbda0b3f7, 32'h2aadbce4,
    32'hbda255b3, 32'h8642a477, 32'h3405d822, 32'h23097d22};
`endif

  sha256_core_mb #(.rounds_per_cycle_p(1), .core_id_p("r1")) u_r1 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i[0]), .v_i(v_i[0]),
    .ready_o(ready_o[0]), .msg_i(msg_i), .first_i(first_i),
    .last_i(last_i),
`ifdef SHA256_CORE_SHA224_EN
    .mode_i(mode_i),
`endif
    .v_o(v_o[0]), .yumi_i(yumi_i[0]), .digest_o(dig[0]));

  sha256_core_mb #(.rounds_per_cycle_p(2), .core_id_p("r2")) u_r2 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i[1]), .v_i(v_i[1]),
    .ready_o(ready_o[1]), .msg_i(msg_i), .first_i(first_i),
    .last_i(last_i),
`ifdef SHA256_CORE_SHA224_EN
    .mode_i(mode_i),
`endif
    .v_o(v_o[1]), .yumi_i(yumi_i[1]), .digest_o(dig[1]));

  sha256_core_mb #(.rounds_per_cycle_p(4), .core_id_p("r4")) u_r4 (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i[2]), .v_i(v_i[2]),
    .ready_o(ready_o[2]), .msg_i(msg_i), .first_i(first_i),
    .last_i(last_i),
`ifdef SHA256_CORE_SHA224_EN
    .mode_i(mode_i),
`endif
    .v_o(v_o[2]), .yumi_i(yumi_i[2]), .digest_o(dig[2]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int s, input logic [511:0] m,
                      input logic f, input logic l);
    @(negedge clk);
    msg_i   = m;
    first_i = f;
    last_i  = l;
    v_i[s]  = 1'b1;
    @(posedge clk);
    #1;
    v_i[s]  = 1'b0;
  endtask

  task automatic wait_v(input int s, output int n);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (v_o[s]) break;
    end
  endtask

  task automatic wait_rdy(input int s, output int n, output logic saw_v);
    n = 0;
    saw_v = 1'b0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      saw_v |= v_o[s];
      if (ready_o[s]) break;
    end
  endtask

  task automatic pop(input int s, input string tag);
    @(negedge clk);
    yumi_i[s] = 1'b1;
    @(posedge clk);
    #1;
    yumi_i[s] = 1'b0;
    chk({tag, "_vo_low"}, v_o[s], 1'b0);
    chk({tag, "_rdy"}, ready_o[s], 1'b1);
  endtask

  initial begin
    int n;
    int cyc;
    logic sv;
    logic [255:0] held;
    reset_i = 1'b1;
    en_i    = 3'b111;
    v_i     = '0;
    yumi_i  = '0;
    msg_i   = '0;
    first_i = 1'b0;
    last_i  = 1'b0;
`ifdef SHA256_CORE_SHA224_EN
    mode_i  = 1'b0;
`endif
    #12;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_rdy%0d", s), ready_o[s], 1'b1);
      chk($sformatf("rst_vo%0d", s), v_o[s], 1'b0);
      chk($sformatf("rst_dig%0d", s), dig[s], '0);
    end
    @(negedge clk);
    reset_i = 1'b0;

    // "abc" single block at R=1
    send(0, MSG_ABC, 1'b1, 1'b1);
    chk("r1_busy_rdy", ready_o[0], 1'b0);
    wait_v(0, n);
    chk("r1_lat", n, 65);
    chk("r1_dig", dig[0], DIG_ABC);
    pop(0, "r1");

    // two-block message at R=4
    send(2, MSG_B1, 1'b1, 1'b0);
    wait_rdy(2, n, sv);
    chk("r4_b1_lat", n, 17);
    chk("r4_b1_novo", sv, 1'b0);
    chk("r4_b1_dig", dig[2], '0);
    send(2, MSG_B2, 1'b0, 1'b1);
    wait_v(2, n);
    chk("r4_b2_lat", n, 17);
    chk("r4_b2_dig", dig[2], DIG_2B);
    pop(2, "r4b2");

    // back-to-back "abc" at R=4, IV reload after the two-block message
    send(2, MSG_ABC, 1'b1, 1'b1);
    wait_v(2, n);
    chk("bb1_dig", dig[2], DIG_ABC);
    pop(2, "bb1");
    send(2, MSG_ABC, 1'b1, 1'b1);
    wait_v(2, n);
    chk("bb2_lat", n, 17);
    chk("bb2_dig", dig[2], DIG_ABC);
    pop(2, "bb2");

    // stall and backpressure at R=2
    send(1, MSG_ABC, 1'b1, 1'b1);
    n = 0;
    cyc = 0;
    while (!v_o[1] && cyc < 400) begin
      @(negedge clk);
      en_i[1] = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (en_i[1]) n++;
      #1;
      cyc++;
    end
    @(negedge clk);
    en_i[1] = 1'b1;
    chk("st_vo", v_o[1], 1'b1);
    chk("st_en_edges", n, 33);
    chk("st_dig", dig[1], DIG_ABC);
    held = dig[1];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v_i[1]  = 1'(i % 2);
      msg_i   = {16{$urandom}};
      first_i = 1'b1;
      last_i  = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("hold_vo%0d", i), v_o[1], 1'b1);
      chk($sformatf("hold_dig%0d", i), dig[1], held);
    end
    @(negedge clk);
    v_i[1]    = 1'b0;
    en_i[1]   = 1'b0;
    yumi_i[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("yumi_en_low", v_o[1], 1'b1);
    @(negedge clk);
    en_i[1]   = 1'b1;
    yumi_i[1] = 1'b0;
    pop(1, "st");
    chk("st_dig_after", dig[1], DIG_ABC);

    // reset mid-eBusy at round 30, R=1
    send(0, MSG_B1, 1'b1, 1'b1);
    repeat (30) @(posedge clk);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mr_rdy", ready_o[0], 1'b1);
    chk("mr_vo", v_o[0], 1'b0);
    chk("mr_dig", dig[0], '0);
    chk("mr_dig2", dig[2], '0);
    @(negedge clk);
    reset_i = 1'b0;
    send(0, MSG_ABC, 1'b0, 1'b1);
    wait_v(0, n);
    chk("mr_lat", n, 65);
    chk("mr_abc", dig[0], DIG_ABC);
    pop(0, "mr");

`ifdef SHA256_CORE_SHA224_EN
    mode_i = 1'b1;
    send(2, MSG_ABC, 1'b1, 1'b1);
    mode_i = 1'b0;
    wait_v(2, n);
    chk("s224_dig", dig[2], DIG_224);
    pop(2, "s224");
`endif

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
